// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared sizing constants and FSM state type for the nibble-serial subtractor.
package sub_pkg;

  localparam int WIDTH      = 16;
  localparam int DIGIT      = 4;
  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_digit.sv
// Combinational DIGIT-bit subtract slice: a + ~b + ~bin with a lookahead carry.
module digit_subtractor #(
  parameter int DIGIT = sub_pkg::DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT-1:0] p;
  logic [DIGIT-1:0] g;
  logic [DIGIT:0]   c;

  assign p = a ^ ~b;
  assign g = a & ~b;

  // Each carry is expanded as a flat sum of generate/propagate products.
  always_comb begin
    logic term_v;
    logic prop_v;
    c      = '0;
    c[0]   = ~bin;
    term_v = 1'b0;
    prop_v = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      term_v = g[i];
      prop_v = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term_v = term_v | (prop_v & g[j]);
        prop_v = prop_v & p[j];
      end
      c[i+1] = term_v | (prop_v & c[0]);
    end
  end

  assign d    = p ^ c[DIGIT-1:0];
  assign bout = ~c[DIGIT];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle A - B - Bin, one DIGIT-bit slice per clock, with valid/ready on
// both the operand and the result side.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = sub_pkg::WIDTH,
  parameter int DIGIT = sub_pkg::DIGIT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Bin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] Diff_o,
  output logic             Bout_o,
  output logic             Ovf_o,
  output logic             Zero_o
);

  localparam int            SLICES = WIDTH / DIGIT;
  localparam int            CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST   = CW'(SLICES - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    cnt_reg;
  logic             borrow_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_next;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bout;
  logic             accept;
  logic             last_slice;

  assign slice_a = a_reg[cnt_reg*DIGIT +: DIGIT];
  assign slice_b = b_reg[cnt_reg*DIGIT +: DIGIT];

  digit_subtractor #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a   (slice_a),
    .b   (slice_b),
    .bin (borrow_reg),
    .d   (slice_d),
    .bout(slice_bout)
  );

  always_comb begin
    work_next                         = work_reg;
    work_next[cnt_reg*DIGIT +: DIGIT] = slice_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_next = CALC;
      end
      CALC: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = (state_reg == IDLE) && valid_i;
  assign last_slice = (state_reg == CALC) && (cnt_reg == LAST);

  // Published results only change on the last slice, so they stay stable in
  // DONE and remain readable (though stale) back in IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      work_reg   <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else if (accept) begin
      a_reg      <= A_i;
      b_reg      <= B_i;
      borrow_reg <= Bin_i;
      cnt_reg    <= '0;
      work_reg   <= '0;
    end else if (state_reg == CALC) begin
      work_reg   <= work_next;
      borrow_reg <= slice_bout;
      cnt_reg    <= cnt_reg + CW'(1);
      if (last_slice) begin
        diff_reg <= work_next;
        bout_reg <= slice_bout;
        ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                    (work_next[WIDTH-1] != a_reg[WIDTH-1]);
        zero_reg <= (work_next == '0);
      end
    end
  end

  assign Diff_o = diff_reg;
  assign Bout_o = bout_reg;
  assign Ovf_o  = ovf_reg;
  assign Zero_o = zero_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomised and directed checks of nibble_serial_subtractor against an
// integer-arithmetic reference model.
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] A_i;
  logic [15:0] B_i;
  logic        Bin_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] Diff_o;
  logic        Bout_o;
  logic        Ovf_o;
  logic        Zero_o;

  int total = 0;
  int bad   = 0;

  nibble_serial_subtractor dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .A_i    (A_i),
    .B_i    (B_i),
    .Bin_i  (Bin_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .Diff_o (Diff_o),
    .Bout_o (Bout_o),
    .Ovf_o  (Ovf_o),
    .Zero_o (Zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference: plain integer subtraction, signed range check for overflow.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                output logic [15:0] d, output logic bo, output logic ov,
                                output logic z);
    int u;
    int s;
    u  = int'(a) - int'(b) - int'(bin);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = u[15:0];
    bo = (u < 0);
    ov = (s > 32767) || (s < -32768);
    z  = (d == 16'h0000);
  endfunction

  // Drives one transaction; returns latency (-1 on timeout) and the result
  // sampled after `stall` extra cycles of ready_i=0, then completes the handshake.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input int stall, output int lat, output logic [15:0] d,
                         output logic bo, output logic ov, output logic z);
    int w;
    @(negedge clk);
    w = 0;
    while (ready_o !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    A_i = a; B_i = b; Bin_i = bin; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    A_i = 16'($urandom); B_i = 16'($urandom); Bin_i = 1'($urandom);
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (valid_o !== 1'b1) lat = -1;
    repeat (stall) @(negedge clk);
    d = Diff_o; bo = Bout_o; ov = Ovf_o; z = Zero_o;
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    A_i = 16'h0; B_i = 16'h0; Bin_i = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", ready_o);
    end
    total++;
    if ({valid_o, Diff_o, Bout_o, Ovf_o, Zero_o} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b diff=%h bout=%b ovf=%b zero=%b want all 0",
               valid_o, Diff_o, Bout_o, Ovf_o, Zero_o);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset: checked");
  endtask

  task automatic test_directed();
    logic [15:0] va   [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h5A5A};
    logic [15:0] vb   [5] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'h5A59};
    logic        vbin [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ed   [5] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic [2:0]  ef   [5] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001};
    int          lat;
    logic [15:0] d;
    logic        bo, ov, z;
    for (int i = 0; i < 5; i++) begin
      run_txn(va[i], vb[i], vbin[i], 0, lat, d, bo, ov, z);
      total++;
      if (lat != 4) begin
        bad++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat);
      end
      total++;
      if (d !== ed[i]) begin
        bad++; $display("FAIL directed%0d_diff: got %h want %h", i, d, ed[i]);
      end
      total++;
      if ({bo, ov, z} !== ef[i]) begin
        bad++; $display("FAIL directed%0d_flags: got bout/ovf/zero=%b want %b", i, {bo, ov, z}, ef[i]);
      end
      $display("directed %0d: %h - %h - %b -> %h flags=%b lat=%0d", i, va[i], vb[i], vbin[i], d, {bo, ov, z}, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    A_i = 16'h1234; B_i = 16'h0234; Bin_i = 1'b0; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    total++;
    if (lat != 4) begin
      bad++; $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'($urandom); A_i = 16'($urandom); B_i = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({valid_o, ready_o, Diff_o, Bout_o, Ovf_o, Zero_o} !== {1'b1, 1'b0, 16'h1000, 3'b000}) begin
        bad++;
        $display("FAIL bp_hold%0d: got valid=%b ready=%b diff=%h flags=%b want 1 0 1000 000",
                 i, valid_o, ready_o, Diff_o, {Bout_o, Ovf_o, Zero_o});
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    total++;
    if ({ready_o, valid_o, Diff_o} !== {1'b1, 1'b0, 16'h1000}) begin
      bad++;
      $display("FAIL bp_release: got ready=%b valid=%b diff=%h want 1 0 1000", ready_o, valid_o, Diff_o);
    end
    $display("test_backpressure: latency=%0d", lat);
  endtask

  task automatic test_reset_mid();
    int          lat;
    int          spurious;
    logic [15:0] d;
    logic        bo, ov, z;
    @(negedge clk);
    A_i = 16'h4321; B_i = 16'h0001; Bin_i = 1'b0; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({valid_o, ready_o, Diff_o} !== {1'b0, 1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL midreset_abort: got valid=%b ready=%b diff=%h want 0 1 0000", valid_o, ready_o, Diff_o);
    end
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b0) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++; $display("FAIL midreset_no_valid: got %0d valid cycles want 0", spurious);
    end
    run_txn(16'h0003, 16'h0001, 1'b0, 0, lat, d, bo, ov, z);
    total++;
    if (lat != 4 || d !== 16'h0002 || {bo, ov, z} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_next: got lat=%0d diff=%h flags=%b want 4 0002 000", lat, d, {bo, ov, z});
    end
    $display("test_reset_mid: next result %h lat=%0d", d, lat);
  endtask

  task automatic test_back_to_back();
    int          lat1, lat2;
    logic [15:0] d1, d2, e1, e2;
    logic        bo1, ov1, z1, bo2, ov2, z2;
    logic        eb1, eo1, ez1, eb2, eo2, ez2;
    run_txn(16'hFFFF, 16'h0000, 1'b1, 0, lat1, d1, bo1, ov1, z1);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: got ready=%b valid=%b want 1 0", ready_o, valid_o);
    end
    run_txn(16'h0000, 16'hFFFF, 1'b1, 1, lat2, d2, bo2, ov2, z2);
    model(16'hFFFF, 16'h0000, 1'b1, e1, eb1, eo1, ez1);
    model(16'h0000, 16'hFFFF, 1'b1, e2, eb2, eo2, ez2);
    total++;
    if (lat1 != 4 || {d1, bo1, ov1, z1} !== {e1, eb1, eo1, ez1}) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d %h/%b want 4 %h/%b", lat1, d1, {bo1, ov1, z1}, e1, {eb1, eo1, ez1});
    end
    total++;
    if (lat2 != 4 || {d2, bo2, ov2, z2} !== {e2, eb2, eo2, ez2}) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d %h/%b want 4 %h/%b", lat2, d2, {bo2, ov2, z2}, e2, {eb2, eo2, ez2});
    end
    $display("test_back_to_back: %h then %h", d1, d2);
  endtask

  task automatic test_random(input int n);
    int          lat;
    int          errs_before;
    logic [15:0] a, b, d, e;
    logic        bin, bo, ov, z, eb, eo, ez;
    errs_before = bad;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 16'h8000;
        1:       a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      b   = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      bin = 1'($urandom);
      run_txn(a, b, bin, $urandom_range(0, 3), lat, d, bo, ov, z);
      model(a, b, bin, e, eb, eo, ez);
      total++;
      if (lat != 4 || {d, bo, ov, z} !== {e, eb, eo, ez}) begin
        bad++;
        $display("FAIL random%0d: %h-%h-%b got lat=%0d %h/%b want 4 %h/%b",
                 i, a, b, bin, lat, d, {bo, ov, z}, e, {eb, eo, ez});
      end
    end
    $display("test_random: %0d transactions, %0d errors", n, bad - errs_before);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random(1500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
